// File: rtl/sdp_ram_param_be.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read latency and selectable read-during-write.
// Optional macro SDP_RAM_COLLISION_FLAG_EN adds the rd_collision output.
module sdp_ram_param_be #(
  parameter int DATA_W     = 36,
  parameter int BYTE_W     = 9,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        dout,
  output logic                     rd_valid
`ifdef SDP_RAM_COLLISION_FLAG_EN
  ,
  output logic                     rd_collision
`endif
);

  localparam int LANES = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  genvar gi;

  generate
    if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
      $error("sdp_ram_param_be: DATA_W must be a multiple of BYTE_W");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("sdp_ram_param_be: RD_LATENCY must be 1 or 2");
    end
    if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("sdp_ram_param_be: DEPTH exceeds address space");
    end
  endgenerate

  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     ram_q_reg;
  logic [DATA_W-1:0]     rd_word;
  logic [DATA_W-1:0]     stage1_data;
  logic                  v1_reg;
  logic                  zero_reg;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst_n && we && wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Plain registered read; the array read always sees the pre-write word.
  always_ff @(posedge clk) begin
    if (rst_n && re && rd_ok) begin
      ram_q_reg <= mem[rd_addr];
    end
  end

  // zero_reg forces dout to zero after reset and for out-of-range reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg   <= 1'b0;
      zero_reg <= 1'b1;
    end else begin
      v1_reg <= re;
      if (re) begin
        zero_reg <= !rd_ok;
      end
    end
  end

  generate
    if (RDW_MODE == 1) begin : g_write_first
      logic                  byp_reg;
      logic [LANES-1:0]      byp_be_reg;
      logic [DATA_W-1:0]     byp_din_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          byp_reg <= 1'b0;
        end else if (re) begin
          byp_reg <= we && (rd_addr == wr_addr);
        end
      end

      always_ff @(posedge clk) begin
        if (rst_n && re) begin
          byp_be_reg  <= wr_be;
          byp_din_reg <= din;
        end
      end

      // Written lanes come from the captured write data, the rest from the old word.
      for (gi = 0; gi < LANES; gi++) begin : g_lane
        assign rd_word[gi*BYTE_W +: BYTE_W] = (byp_reg && byp_be_reg[gi]) ?
            byp_din_reg[gi*BYTE_W +: BYTE_W] : ram_q_reg[gi*BYTE_W +: BYTE_W];
      end
    end else begin : g_read_first
      assign rd_word = ram_q_reg;
    end
  endgenerate

  assign stage1_data = zero_reg ? '0 : rd_word;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] dout_reg;
      logic              v2_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_reg <= '0;
          v2_reg   <= 1'b0;
        end else begin
          v2_reg <= v1_reg;
          if (v1_reg) begin
            dout_reg <= stage1_data;
          end
        end
      end

      assign dout     = dout_reg;
      assign rd_valid = v2_reg;
    end else begin : g_lat1
      assign dout     = stage1_data;
      assign rd_valid = v1_reg;
    end
  endgenerate

`ifdef SDP_RAM_COLLISION_FLAG_EN
  logic coll1_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll1_reg <= 1'b0;
    end else begin
      coll1_reg <= re && we && (|wr_be) && (rd_addr == wr_addr);
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_coll2
      logic coll2_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          coll2_reg <= 1'b0;
        end else begin
          coll2_reg <= coll1_reg;
        end
      end
      assign rd_collision = coll2_reg;
    end else begin : g_coll1
      assign rd_collision = coll1_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_sdp_ram_param_be.sv
// Scoreboard bench: two RAM configurations (1024/lat1/read-first and 1000/lat2/write-first) on shared stimulus.
module tb_sdp_ram_param_be;

  typedef struct {
    int          due;
    logic [35:0] data;
    logic        coll;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [9:0]  wr_addr = '0;
  logic [35:0] din = '0;
  logic        re = 1'b0;
  logic [9:0]  rd_addr = '0;

  logic [35:0] dout_a, dout_b;
  logic        valid_a, valid_b;
  logic        coll_a, coll_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [35:0] held_a = '0;
  logic [35:0] held_b = '0;
  logic [35:0] mem_a [1024];
  logic [35:0] mem_b [1024];

  always #5 clk = ~clk;

  sdp_ram_param_be #(
    .DATA_W(36), .BYTE_W(9), .ADDR_W(10), .DEPTH(1024), .RD_LATENCY(1), .RDW_MODE(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .din(din),
    .re(re), .rd_addr(rd_addr), .dout(dout_a), .rd_valid(valid_a)
`ifdef SDP_RAM_COLLISION_FLAG_EN
    , .rd_collision(coll_a)
`endif
  );

  sdp_ram_param_be #(
    .DATA_W(36), .BYTE_W(9), .ADDR_W(10), .DEPTH(1000), .RD_LATENCY(2), .RDW_MODE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .din(din),
    .re(re), .rd_addr(rd_addr), .dout(dout_b), .rd_valid(valid_b)
`ifdef SDP_RAM_COLLISION_FLAG_EN
    , .rd_collision(coll_b)
`endif
  );

`ifndef SDP_RAM_COLLISION_FLAG_EN
  assign coll_a = 1'b0;
  assign coll_b = 1'b0;
`endif

  function automatic logic [35:0] apply_be(input logic [35:0] old_w, input logic [35:0] new_w,
                                           input logic [3:0] be);
    logic [35:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*9 +: 9] = new_w[i*9 +: 9];
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp_v);
    end
  endtask

  // One stimulus cycle; the reference model decides what each port must show and when.
  task automatic drive(input logic r, input logic w, input logic [3:0] be, input logic [9:0] wa,
                       input logic [35:0] d, input logic rr, input logic [9:0] ra);
    int   e;
    logic coll;
    exp_t x;
    @(negedge clk);
    rst_n = r; we = w; wr_be = be; wr_addr = wa; din = d; re = rr; rd_addr = ra;
    e = cyc + 1;
    if (!r) begin
      while (q_a.size() > 0 && q_a[$].due >= e) void'(q_a.pop_back());
      while (q_b.size() > 0 && q_b[$].due >= e) void'(q_b.pop_back());
    end else begin
      coll = rr && w && (be != 4'b0) && (wa == ra);
      // Read-first: sample the model before this cycle's write.
      if (rr) begin
        x.due = e; x.data = mem_a[ra]; x.coll = coll;
        q_a.push_back(x);
      end
      if (w) begin
        mem_a[wa] = apply_be(mem_a[wa], d, be);
        if (wa < 10'd1000) mem_b[wa] = apply_be(mem_b[wa], d, be);
      end
      // Write-first: sample after the write; beyond DEPTH reads return zero.
      if (rr) begin
        x.due = e + 1; x.data = (ra < 10'd1000) ? mem_b[ra] : 36'h0; x.coll = coll;
        q_b.push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 4'h0, 10'd0, 36'h0, 1'b0, 10'd0);
  endtask

  task automatic check_port(input bit is_b, input bit in_rst, input logic v, input logic [35:0] d,
                            input logic c);
    exp_t  e;
    bit    have;
    string p;
    p = is_b ? "B" : "A";
    have = 1'b0;
    if (!is_b && q_a.size() > 0 && q_a[0].due <= cyc) begin e = q_a.pop_front(); have = 1'b1; end
    if (is_b && q_b.size() > 0 && q_b[0].due <= cyc) begin e = q_b.pop_front(); have = 1'b1; end
    if (in_rst) begin
      cmp({p, ".rst_valid"}, {35'h0, v}, 36'h0);
      cmp({p, ".rst_dout"}, d, 36'h0);
      if (is_b) held_b = '0; else held_a = '0;
    end else if (have) begin
      cmp({p, ".valid"}, {35'h0, v}, 36'h1);
      cmp({p, ".dout"}, d, e.data);
`ifdef SDP_RAM_COLLISION_FLAG_EN
      cmp({p, ".collision"}, {35'h0, c}, {35'h0, e.coll});
`endif
      if (is_b) held_b = e.data; else held_a = e.data;
    end else begin
      cmp({p, ".idle_valid"}, {35'h0, v}, 36'h0);
      cmp({p, ".hold_dout"}, d, is_b ? held_b : held_a);
    end
  endtask

  // Monitor: checks every cycle, 1 time unit after the rising edge.
  initial begin
    bit rst_s;
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = !rst_n;
      #1;
      check_port(1'b0, rst_s, valid_a, dout_a, coll_a);
      check_port(1'b1, rst_s, valid_b, dout_b, coll_b);
    end
  end

  initial begin
    logic [63:0] r64;
    logic [9:0]  wa, ra;
    logic        rr, w, rs;

    // Reset held for 3 cycles with re asserted: nothing may come out.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0, 10'd0, 36'h0, 1'b1, 10'd3);
    idle(2);

    // Fill every address, then read all back to back (B returns zero beyond 999).
    for (int a = 0; a < 1024; a++) begin
      r64 = {$urandom, $urandom};
      drive(1'b1, 1'b1, 4'hF, 10'(a), r64[35:0], 1'b0, 10'd0);
    end
    for (int a = 0; a < 1024; a++) drive(1'b1, 1'b0, 4'h0, 10'd0, 36'h0, 1'b1, 10'(a));
    idle(3);

    // Byte-lane merge on address 5.
    drive(1'b1, 1'b1, 4'hF, 10'd5, 36'hF_FFFF_FFFF, 1'b0, 10'd0);
    drive(1'b1, 1'b1, 4'b0101, 10'd5, 36'h0, 1'b0, 10'd0);
    drive(1'b1, 1'b1, 4'b0000, 10'd5, 36'h0, 1'b0, 10'd0);
    drive(1'b1, 1'b0, 4'h0, 10'd0, 36'h0, 1'b1, 10'd5);
    idle(3);

    // Back-to-back reads after back-to-back writes.
    for (int a = 1; a <= 4; a++) drive(1'b1, 1'b1, 4'hF, 10'(a), 36'(a), 1'b0, 10'd0);
    for (int a = 1; a <= 4; a++) drive(1'b1, 1'b0, 4'h0, 10'd0, 36'h0, 1'b1, 10'(a));
    idle(3);

    // Same-edge collisions: full and partial byte enables, and out of range.
    drive(1'b1, 1'b1, 4'hF, 10'd7, 36'h0_0000_00AA, 1'b0, 10'd0);
    drive(1'b1, 1'b1, 4'hF, 10'd7, 36'h0_0000_0055, 1'b1, 10'd7);
    drive(1'b1, 1'b1, 4'b0010, 10'd7, 36'h1_2345_6789, 1'b1, 10'd7);
    drive(1'b1, 1'b1, 4'hF, 10'd1010, 36'h9_8765_4321, 1'b1, 10'd1010);
    drive(1'b1, 1'b0, 4'h0, 10'd0, 36'h0, 1'b1, 10'd7);
    idle(3);

    // Reset in the middle of a read: B's result is dropped, memory survives.
    drive(1'b1, 1'b1, 4'hF, 10'd9, 36'hA_BCDE_F012, 1'b0, 10'd0);
    drive(1'b1, 1'b0, 4'h0, 10'd0, 36'h0, 1'b1, 10'd9);
    drive(1'b0, 1'b1, 4'hF, 10'd9, 36'h0, 1'b1, 10'd9);
    idle(2);
    drive(1'b1, 1'b0, 4'h0, 10'd0, 36'h0, 1'b1, 10'd9);
    idle(3);

    // Random traffic with frequent address collisions and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r64 = {$urandom, $urandom};
      wa  = 10'($urandom_range(0, 1023));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 10'($urandom_range(0, 1023));
      rr  = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 199) != 0);
      drive(rs, w, 4'($urandom), wa, r64[35:0], rr, ra);
    end
    idle(4);

    cmp("drain_a", 36'(q_a.size()), 36'h0);
    cmp("drain_b", 36'(q_b.size()), 36'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
